bcd_countdown_timer: RTL and testbench
======================================

Name: bcd_countdown_timer

Overview:
Two-digit BCD down-counter (99..00) that consumes a one-cycle count strobe, such as the roll output of an upstream mod-10 up-counter or a prescaler. It is the decrementing complement to the up-counting digit chain. It provides load, start, pause, a borrow pulse per tens decrement, and a done pulse on expiry. It sits between the tick generator and the display/alarm logic.

Parameters:
AUTO_RELOAD, 0, 1 = on expiry reload the last loaded value and keep running; 0 = stop in EXPIRED

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
load  input  1  synchronous load of loadTens/loadOnes
loadTens  input  4  BCD tens value to load
loadOnes  input  4  BCD ones value to load
start  input  1  begin or resume counting
pause  input  1  suspend counting
enb  input  1  count strobe; one decrement per high cycle while RUN
tens  output  4  current tens digit, BCD
ones  output  4  current ones digit, BCD
borrow  output  1  one-cycle pulse when ones wraps 0->9
done  output  1  one-cycle pulse when count reaches 00
running  output  1  high while state is RUN

Behaviour:
- All outputs are registered. The design uses clk only and has no combinational input-to-output paths.
- Reset (async, active-high): state=IDLE; tens=0, ones=0, borrow=0, done=0, running=0; shadow reload register=00.
- States: IDLE, RUN, PAUSED, EXPIRED. running=1 only in RUN.
- Priority each cycle: load > pause > start > enb.
- load (any state):
  - tens<=loadTens and ones<=loadOnes, written to the count and the shadow register.
  - Nibbles >9 clamp to 9.
  - Next state is IDLE. A start in the same cycle is ignored. borrow/done stay 0.
- IDLE:
  - start with count!=00 -> RUN next cycle.
  - start with count==00 -> remain IDLE; done is not pulsed.
  - enb is ignored.
- RUN, with enb=1 and pause=0:
  - ones!=0: ones-1, tens unchanged.
  - ones==0 and tens!=0: ones=9, tens-1, borrow=1 for that cycle.
  - Count 01 -> 00: done=1 for that cycle, registered on the same edge as the count reaching 00. borrow=0.
    - AUTO_RELOAD=0: state -> EXPIRED.
    - AUTO_RELOAD=1: count <= shadow value in the following cycle; stay in RUN.
    - Shadow value 00 with AUTO_RELOAD=1: go to EXPIRED instead.
- RUN, with pause=1: -> PAUSED. Any decrement in that cycle is suppressed, even if enb=1.
- RUN, with enb=0: hold.
- PAUSED:
  - start -> RUN, with counting resuming on the next enb.
  - enb is ignored; the count holds.
- EXPIRED:
  - count holds at 00; start, pause, and enb are ignored.
  - Only load or reset exits.
- borrow and done are never high simultaneously. Each is exactly one cycle wide, even if enb is held high continuously.
- A continuously high enb in RUN decrements once per clock.
- Reset asserted mid-count immediately clears outputs (async). Counting does not resume after reset deassertion until load and start.
- BCD invariant: each digit is always in 0..9.

Test Plan:
- Reset then idle: reset=1 for 5 ns, then 0 -> tens=0, ones=0, running=0, borrow=0, done=0; start alone leaves state IDLE and done=0.
- Load and count through borrow: load 1,2 (12); start; 3 enb pulses -> 11, 10, 09. borrow=1 exactly in the cycle 09 appears; running=1 throughout.
- Expiry, AUTO_RELOAD=0: load 0,3; start; hold enb=1 -> 02, 01, 00 on consecutive clocks. done=1 for one cycle at 00; state EXPIRED (running=0). Further enb and start leave 00 with done=0.
- Pause/resume: load 2,0; start; enb once -> 19. Assert pause together with enb -> stays 19, running=0. 4 enb pulses while PAUSED -> still 19. start, then enb -> 18.
- Clamp and load priority: load with loadTens=4'hC, loadOnes=4'hF while RUN and start=1 -> 99, state IDLE, running=0.
- AUTO_RELOAD=1: load 0,2; start; enb x2 -> 01, 00 (done=1), then 02 on the next clock with running=1. Separately, assert reset mid-count at 01 -> outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: two-digit BCD down-counter with load/start/pause, borrow and done pulses
module bcd_countdown_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] loadTens,
  input  logic [3:0] loadOnes,
  input  logic       start,
  input  logic       pause,
  input  logic       enb,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       borrow,
  output logic       done,
  output logic       running
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] PAUSED  = 2'd2;
  localparam logic [1:0] EXPIRED = 2'd3;
  logic [1:0] state_q, state_d;
  logic [3:0] tens_q, tens_d, ones_q, ones_d;
  logic [3:0] sh_tens_q, sh_tens_d, sh_ones_q, sh_ones_d;
  logic       borrow_q, borrow_d, done_q, done_d, running_q;
  logic       reload_q, reload_d;
  logic       nonzero;
  assign nonzero = (tens_q != 4'd0) || (ones_q != 4'd0);
  // next-state: load beats pause beats start beats enb; reload_q restores the shadow one cycle after expiry
  always_comb begin
    state_d   = state_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    sh_tens_d = sh_tens_q;
    sh_ones_d = sh_ones_q;
    borrow_d  = 1'b0;
    done_d    = 1'b0;
    reload_d  = 1'b0;
    if (load) begin
      tens_d    = (loadTens > 4'd9) ? 4'd9 : loadTens;
      ones_d    = (loadOnes > 4'd9) ? 4'd9 : loadOnes;
      sh_tens_d = tens_d;
      sh_ones_d = ones_d;
      state_d   = IDLE;
    end else begin
      if (reload_q) begin
        tens_d = sh_tens_q;
        ones_d = sh_ones_q;
      end
      if (state_q == IDLE) begin
        state_d = (!pause && start && nonzero) ? RUN : IDLE;
      end else if (state_q == RUN) begin
        if (pause) begin
          state_d = PAUSED;
        end else if (enb && !reload_q && nonzero) begin
          ones_d   = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
          tens_d   = (ones_q == 4'd0) ? tens_q - 4'd1 : tens_q;
          borrow_d = (ones_q == 4'd0);
          done_d   = (tens_q == 4'd0) && (ones_q == 4'd1);
          reload_d = done_d && AUTO_RELOAD && ((sh_tens_q != 4'd0) || (sh_ones_q != 4'd0));
          state_d  = (done_d && !reload_d) ? EXPIRED : RUN;
        end
      end else if (state_q == PAUSED) begin
        state_d = (!pause && start) ? RUN : PAUSED;
      end
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      sh_tens_q <= 4'd0;
      sh_ones_q <= 4'd0;
      borrow_q  <= 1'b0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      reload_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      sh_tens_q <= sh_tens_d;
      sh_ones_q <= sh_ones_d;
      borrow_q  <= borrow_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
      reload_q  <= reload_d;
    end
  end
  assign tens    = tens_q;
  assign ones    = ones_q;
  assign borrow  = borrow_q;
  assign done    = done_q;
  assign running = running_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed vector table plus hand sequences for auto-reload and async reset
module tb_bcd_countdown_timer;
  typedef struct packed {
    logic       ld;
    logic [3:0] lt;
    logic [3:0] lo;
    logic       st;
    logic       pa;
    logic       en;
  } in_t;
  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       borrow;
    logic       done;
    logic       running;
  } out_t;
  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;
  logic clk = 1'b1;
  logic reset0 = 1'b1;
  logic reset1 = 1'b1;
  in_t  in0 = '0;
  in_t  in1 = '0;
  out_t out0, out1;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  bcd_countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset0), .load(in0.ld), .loadTens(in0.lt), .loadOnes(in0.lo),
    .start(in0.st), .pause(in0.pa), .enb(in0.en),
    .tens(out0.tens), .ones(out0.ones), .borrow(out0.borrow), .done(out0.done), .running(out0.running)
  );
  bcd_countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset1), .load(in1.ld), .loadTens(in1.lt), .loadOnes(in1.lo),
    .start(in1.st), .pause(in1.pa), .enb(in1.en),
    .tens(out1.tens), .ones(out1.ones), .borrow(out1.borrow), .done(out1.done), .running(out1.running)
  );
  function automatic in_t mk(input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                             input logic st, input logic pa, input logic en);
    return '{ld: ld, lt: lt, lo: lo, st: st, pa: pa, en: en};
  endfunction
  function automatic out_t ex(input logic [3:0] t, input logic [3:0] o,
                              input logic b, input logic d, input logic r);
    return '{tens: t, ones: o, borrow: b, done: d, running: r};
  endfunction
  task automatic check(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got tens=%h ones=%h borrow=%b done=%b running=%b, expected tens=%h ones=%h borrow=%b done=%b running=%b",
               name, got.tens, got.ones, got.borrow, got.done, got.running,
               exp.tens, exp.ones, exp.borrow, exp.done, exp.running);
    end
  endtask
  task automatic step(input int sel, input in_t v);
    @(negedge clk);
    if (sel == 0) in0 = v; else in1 = v;
    @(posedge clk);
    #1;
  endtask
  vec_t tbl[28];
  initial begin
    tbl[0]  = '{mk(0,0,0,1,0,0), ex(0,0,0,0,0)};
    tbl[1]  = '{mk(1,1,2,0,0,0), ex(1,2,0,0,0)};
    tbl[2]  = '{mk(0,0,0,1,0,0), ex(1,2,0,0,1)};
    tbl[3]  = '{mk(0,0,0,0,0,1), ex(1,1,0,0,1)};
    tbl[4]  = '{mk(0,0,0,0,0,1), ex(1,0,0,0,1)};
    tbl[5]  = '{mk(0,0,0,0,0,1), ex(0,9,1,0,1)};
    tbl[6]  = '{mk(0,0,0,0,0,0), ex(0,9,0,0,1)};
    tbl[7]  = '{mk(1,0,3,0,0,0), ex(0,3,0,0,0)};
    tbl[8]  = '{mk(0,0,0,1,0,0), ex(0,3,0,0,1)};
    tbl[9]  = '{mk(0,0,0,0,0,1), ex(0,2,0,0,1)};
    tbl[10] = '{mk(0,0,0,0,0,1), ex(0,1,0,0,1)};
    tbl[11] = '{mk(0,0,0,0,0,1), ex(0,0,0,1,0)};
    tbl[12] = '{mk(0,0,0,0,0,1), ex(0,0,0,0,0)};
    tbl[13] = '{mk(0,0,0,1,0,0), ex(0,0,0,0,0)};
    tbl[14] = '{mk(0,0,0,1,0,1), ex(0,0,0,0,0)};
    tbl[15] = '{mk(1,2,0,0,0,0), ex(2,0,0,0,0)};
    tbl[16] = '{mk(0,0,0,1,0,0), ex(2,0,0,0,1)};
    tbl[17] = '{mk(0,0,0,0,0,1), ex(1,9,1,0,1)};
    tbl[18] = '{mk(0,0,0,0,1,1), ex(1,9,0,0,0)};
    tbl[19] = '{mk(0,0,0,0,0,1), ex(1,9,0,0,0)};
    tbl[20] = '{mk(0,0,0,0,0,1), ex(1,9,0,0,0)};
    tbl[21] = '{mk(0,0,0,0,0,1), ex(1,9,0,0,0)};
    tbl[22] = '{mk(0,0,0,0,0,1), ex(1,9,0,0,0)};
    tbl[23] = '{mk(0,0,0,1,0,0), ex(1,9,0,0,1)};
    tbl[24] = '{mk(0,0,0,0,0,1), ex(1,8,0,0,1)};
    tbl[25] = '{mk(1,4'hC,4'hF,1,0,0), ex(9,9,0,0,0)};
    tbl[26] = '{mk(0,0,0,1,0,0), ex(9,9,0,0,1)};
    tbl[27] = '{mk(0,0,0,0,0,1), ex(9,8,0,0,1)};
    #5;
    reset0 = 1'b0;
    reset1 = 1'b0;
    #1;
    check("reset_dut0", out0, ex(0,0,0,0,0));
    check("reset_dut1", out1, ex(0,0,0,0,0));
    for (int i = 0; i < 28; i++) begin
      step(0, tbl[i].i);
      check($sformatf("vec%0d", i), out0, tbl[i].o);
    end
    step(1, mk(1,0,2,0,0,0)); check("ar_load",   out1, ex(0,2,0,0,0));
    step(1, mk(0,0,0,1,0,0)); check("ar_start",  out1, ex(0,2,0,0,1));
    step(1, mk(0,0,0,0,0,1)); check("ar_01",     out1, ex(0,1,0,0,1));
    step(1, mk(0,0,0,0,0,1)); check("ar_00",     out1, ex(0,0,0,1,1));
    step(1, mk(0,0,0,0,0,1)); check("ar_reload", out1, ex(0,2,0,0,1));
    step(1, mk(0,0,0,0,0,1)); check("ar_01b",    out1, ex(0,1,0,0,1));
    #2;
    reset1 = 1'b1;
    #1;
    check("async_reset", out1, ex(0,0,0,0,0));
    @(negedge clk);
    reset1 = 1'b0;
    step(1, mk(0,0,0,0,0,1)); check("post_reset_enb",   out1, ex(0,0,0,0,0));
    step(1, mk(0,0,0,1,0,1)); check("post_reset_start", out1, ex(0,0,0,0,0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
